// File: rtl/mig_if_pkg.sv
// Shared MIG user-interface constants, request layout helpers and issuer state encoding.
package mig_if_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Request word is {we, addr, wdata} with wdata in the LSBs.
  localparam int DATA_LSB = 0;

  function automatic int addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int we_bit(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/mig_cmd_issuer.sv
// Pops one request at a time from the request FIFO, drives it onto the MIG app_* interface,
// tracks reads in flight and returns read data on a registered response port.
module mig_cmd_issuer
  import mig_if_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int MAX_RD = 4,
  parameter int CNT_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       calib_done,
  input  logic                       fifo_empty,
  input  logic [ADDR_W+DATA_W:0]     fifo_data,
  output logic                       fifo_pop,
  output logic                       app_en,
  output logic [2:0]                 app_cmd,
  output logic [ADDR_W-1:0]          app_addr,
  input  logic                       app_rdy,
  output logic [DATA_W-1:0]          app_wdf_data,
  output logic                       app_wdf_wren,
  output logic                       app_wdf_end,
  input  logic                       app_wdf_rdy,
  input  logic [DATA_W-1:0]          app_rd_data,
  input  logic                       app_rd_data_valid,
  output logic                       rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       busy,
  output logic                       err_underflow
);

  localparam int WE_BIT   = we_bit(ADDR_W, DATA_W);
  localparam int ADDR_LSB = addr_lsb(DATA_W);

  state_e              state_q, state_d;
  logic                req_we_q;
  logic [2:0]          req_cmd_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [DATA_W-1:0]   req_data_q;
  logic                cmd_done_q, wdf_done_q;
  logic [CNT_W-1:0]    rd_cnt_q;
  logic                err_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;

  logic head_we, rd_room, pop;
  logic cmd_acc, wdf_acc, cmd_fin, wdf_fin, rd_inc, rd_dec;

  assign head_we = fifo_data[WE_BIT];
  assign rd_room = (rd_cnt_q < CNT_W'(MAX_RD));
  // Pop is gated by rst so nothing leaves the FIFO while the block is being reset.
  assign pop     = !rst && (state_q == IDLE) && calib_done && !fifo_empty && (head_we || rd_room);

  assign app_en       = (state_q == ISSUE) && !cmd_done_q;
  assign app_wdf_wren = (state_q == ISSUE) && req_we_q && !wdf_done_q;
  assign app_wdf_end  = app_wdf_wren;
  assign app_cmd      = req_cmd_q;
  assign app_addr     = req_addr_q;
  assign app_wdf_data = req_data_q;

  assign cmd_acc = app_en & app_rdy;
  assign wdf_acc = app_wdf_wren & app_wdf_rdy;
  assign cmd_fin = cmd_done_q | cmd_acc;
  assign wdf_fin = wdf_done_q | wdf_acc;
  assign rd_inc  = cmd_acc & ~req_we_q;
  assign rd_dec  = app_rd_data_valid;

  assign fifo_pop      = pop;
  assign busy          = (state_q != IDLE) || (rd_cnt_q != '0);
  assign err_underflow = err_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = ISSUE;
      ISSUE:   if (cmd_fin && wdf_fin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_we_q    <= 1'b0;
      req_cmd_q   <= '0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      cmd_done_q  <= 1'b0;
      wdf_done_q  <= 1'b0;
      rd_cnt_q    <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        req_we_q   <= head_we;
        req_cmd_q  <= head_we ? CMD_WRITE : CMD_READ;
        req_addr_q <= fifo_data[ADDR_LSB +: ADDR_W];
        req_data_q <= fifo_data[DATA_LSB +: DATA_W];
        cmd_done_q <= 1'b0;
        wdf_done_q <= ~head_we;
      end else if (state_q == ISSUE) begin
        cmd_done_q <= cmd_fin;
        wdf_done_q <= wdf_fin;
      end
      // Simultaneous accept and return cancel; a lone return at zero flags underflow.
      if (rd_inc && !rd_dec) begin
        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end else if (rd_dec && !rd_inc) begin
        if (rd_cnt_q == '0) err_q <= 1'b1;
        else                rd_cnt_q <= rd_cnt_q - CNT_W'(1);
      end
      rsp_valid_q <= app_rd_data_valid;
      if (app_rd_data_valid) rsp_data_q <= app_rd_data;
    end
  end

endmodule

// File: tb/tb_mig_cmd_issuer.sv
// Directed bench for mig_cmd_issuer: a queue stands in for the request FIFO, expectations are hand-derived.
module tb_mig_cmd_issuer;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int MAX_RD = 4;
  localparam int CNT_W  = 3;
  localparam int REQ_W  = 1 + ADDR_W + DATA_W;

  logic              clk, rst, calib_done, fifo_empty, fifo_pop;
  logic [REQ_W-1:0]  fifo_data;
  logic              app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic [DATA_W-1:0] app_wdf_data, app_rd_data, rsp_data;
  logic              app_rd_data_valid, rsp_valid, busy, err_underflow;

  int n_chk = 0;
  int n_fail = 0;
  int pop_cnt = 0;
  logic [REQ_W-1:0] q[$];

  mig_cmd_issuer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RD(MAX_RD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .calib_done(calib_done), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_pop(fifo_pop), .app_en(app_en), .app_cmd(app_cmd),
    .app_addr(app_addr), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic refresh();
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() == 0) ? '0 : q[0];
  endtask

  task automatic push(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    q.push_back({we, a, d});
    refresh();
  endtask

  // FIFO model: the head leaves just after an edge on which fifo_pop was high.
  always @(posedge clk) begin
    if (fifo_pop === 1'b1) begin
      #1;
      if (q.size() > 0) void'(q.pop_front());
      pop_cnt++;
      refresh();
    end
  end

  task automatic test_reset();
    rst = 1'b1; calib_done = 1'b1; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    app_rd_data = '0; app_rd_data_valid = 1'b0;
    refresh();
    repeat (3) @(negedge clk);
    n_chk++; if ({fifo_pop, app_en, app_wdf_wren, app_wdf_end} !== 4'b0) begin n_fail++; $display("FAIL rst_strobes: got %b want 0000", {fifo_pop, app_en, app_wdf_wren, app_wdf_end}); end
    n_chk++; if ({rsp_valid, busy, err_underflow} !== 3'b0) begin n_fail++; $display("FAIL rst_status: got %b want 000", {rsp_valid, busy, err_underflow}); end
    n_chk++; if ({app_cmd, app_addr} !== '0) begin n_fail++; $display("FAIL rst_cmd_addr: got %h/%h want 0/0", app_cmd, app_addr); end
    n_chk++; if ({app_wdf_data, rsp_data} !== '0) begin n_fail++; $display("FAIL rst_data: got %h/%h want 0/0", app_wdf_data, rsp_data); end
    rst = 1'b0;
  endtask

  task automatic test_write();
    int p0;
    @(negedge clk);
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; p0 = pop_cnt;
    push(1'b1, 28'h0000100, {16{8'hA5}});
    #1;
    n_chk++; if (fifo_pop !== 1'b1) begin n_fail++; $display("FAIL wr_pop: got %b want 1", fifo_pop); end
    @(negedge clk);
    n_chk++; if ({app_en, app_wdf_wren, app_wdf_end} !== 3'b111) begin n_fail++; $display("FAIL wr_valids: got %b want 111", {app_en, app_wdf_wren, app_wdf_end}); end
    n_chk++; if (app_cmd !== 3'b000) begin n_fail++; $display("FAIL wr_cmd: got %b want 000", app_cmd); end
    n_chk++; if (app_addr !== 28'h0000100) begin n_fail++; $display("FAIL wr_addr: got %h want 0000100", app_addr); end
    n_chk++; if (app_wdf_data !== {16{8'hA5}}) begin n_fail++; $display("FAIL wr_data: got %h want a5..a5", app_wdf_data); end
    n_chk++; if (fifo_pop !== 1'b0) begin n_fail++; $display("FAIL wr_no_pop_in_issue: got %b want 0", fifo_pop); end
    @(negedge clk);
    n_chk++; if ({app_en, app_wdf_wren, busy} !== 3'b000) begin n_fail++; $display("FAIL wr_idle: got %b want 000", {app_en, app_wdf_wren, busy}); end
    n_chk++; if (pop_cnt !== p0 + 1) begin n_fail++; $display("FAIL wr_pop_count: got %0d want %0d", pop_cnt, p0 + 1); end
  endtask

  task automatic test_split_accept();
    int p0;
    @(negedge clk);
    app_rdy = 1'b0; app_wdf_rdy = 1'b1; p0 = pop_cnt;
    push(1'b1, 28'h0000200, {4{32'hDEADBEEF}});
    @(negedge clk);
    n_chk++; if ({app_en, app_wdf_wren} !== 2'b11) begin n_fail++; $display("FAIL split_t1: got %b want 11", {app_en, app_wdf_wren}); end
    @(negedge clk);
    n_chk++; if ({app_en, app_wdf_wren, app_wdf_end} !== 3'b100) begin n_fail++; $display("FAIL split_t2: got %b want 100", {app_en, app_wdf_wren, app_wdf_end}); end
    @(negedge clk);
    n_chk++; if ({app_en, busy} !== 2'b11 || app_addr !== 28'h0000200) begin n_fail++; $display("FAIL split_t3: got %b/%h want 11/0000200", {app_en, busy}, app_addr); end
    @(negedge clk);
    n_chk++; if (app_en !== 1'b1) begin n_fail++; $display("FAIL split_t4: got %b want 1", app_en); end
    app_rdy = 1'b1;
    @(negedge clk);
    n_chk++; if ({app_en, busy} !== 2'b00) begin n_fail++; $display("FAIL split_exit: got %b want 00", {app_en, busy}); end
    n_chk++; if (pop_cnt !== p0 + 1) begin n_fail++; $display("FAIL split_single_pop: got %0d want %0d", pop_cnt, p0 + 1); end
  endtask

  task automatic test_read_throttle();
    int p0;
    @(negedge clk);
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; p0 = pop_cnt;
    for (int i = 0; i < 6; i++) push(1'b0, 28'h10 + 28'(i), '0);
    repeat (20) @(negedge clk);
    n_chk++; if (pop_cnt !== p0 + 4) begin n_fail++; $display("FAIL thr_accepted: got %0d want %0d", pop_cnt - p0, 4); end
    n_chk++; if (q.size() !== 2) begin n_fail++; $display("FAIL thr_left: got %0d want 2", q.size()); end
    n_chk++; if ({busy, app_en, fifo_pop} !== 3'b100) begin n_fail++; $display("FAIL thr_stalled: got %b want 100", {busy, app_en, fifo_pop}); end
    app_rd_data = 128'h1234; app_rd_data_valid = 1'b1;
    @(negedge clk);
    app_rd_data_valid = 1'b0;
    n_chk++; if (rsp_valid !== 1'b1 || rsp_data !== 128'h1234) begin n_fail++; $display("FAIL thr_rsp: got %b/%h want 1/1234", rsp_valid, rsp_data); end
    n_chk++; if (fifo_pop !== 1'b1) begin n_fail++; $display("FAIL thr_fifth_pop: got %b want 1", fifo_pop); end
    @(negedge clk);
    n_chk++; if (app_en !== 1'b1 || app_cmd !== 3'b001 || app_addr !== 28'h14) begin n_fail++; $display("FAIL thr_fifth_cmd: got %b/%b/%h want 1/001/0000014", app_en, app_cmd, app_addr); end
    n_chk++; if (rsp_valid !== 1'b0 || rsp_data !== 128'h1234) begin n_fail++; $display("FAIL thr_rsp_hold: got %b/%h want 0/1234", rsp_valid, rsp_data); end
    @(negedge clk);
    n_chk++; if (pop_cnt !== p0 + 5 || q.size() !== 1) begin n_fail++; $display("FAIL thr_after: got pops %0d left %0d want 5/1", pop_cnt - p0, q.size()); end
  endtask

  task automatic test_calib_hold();
    int p0;
    p0 = pop_cnt;
    calib_done = 1'b0; app_rd_data = 128'h1; app_rd_data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) app_rd_data_valid = 1'b0;
      n_chk++; if (fifo_pop !== 1'b0) begin n_fail++; $display("FAIL calib_no_pop[%0d]: got %b want 0", i, fifo_pop); end
    end
    n_chk++; if ({busy, err_underflow} !== 2'b00) begin n_fail++; $display("FAIL calib_drained: got %b want 00", {busy, err_underflow}); end
    n_chk++; if (pop_cnt !== p0 || q.size() !== 1) begin n_fail++; $display("FAIL calib_fifo: got pops %0d left %0d want 0/1", pop_cnt - p0, q.size()); end
  endtask

  task automatic test_concurrent();
    int p0;
    bit found;
    @(negedge clk);
    p0 = pop_cnt; found = 1'b0;
    push(1'b0, 28'h20, '0);
    push(1'b0, 28'h21, '0);
    calib_done = 1'b1;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (pop_cnt == p0 + 3 && app_en === 1'b1) found = 1'b1;
    end
    n_chk++; if (!found) begin n_fail++; $display("FAIL conc_third_read: got no issue within 30 cycles want issue"); end
    app_rd_data = 128'h55; app_rd_data_valid = 1'b1;
    @(negedge clk);
    app_rd_data_valid = 1'b0;
    n_chk++; if ({app_en, busy} !== 2'b01) begin n_fail++; $display("FAIL conc_accepted: got %b want 01", {app_en, busy}); end
    app_rd_data_valid = 1'b1;
    @(negedge clk);
    app_rd_data_valid = 1'b0;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL conc_one_left: got busy %b want 1", busy); end
    app_rd_data_valid = 1'b1;
    @(negedge clk);
    app_rd_data_valid = 1'b0;
    n_chk++; if ({busy, err_underflow} !== 2'b00) begin n_fail++; $display("FAIL conc_drained: got %b want 00", {busy, err_underflow}); end
  endtask

  task automatic test_underflow();
    app_rd_data = 128'h77; app_rd_data_valid = 1'b1;
    @(negedge clk);
    app_rd_data_valid = 1'b0;
    n_chk++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_set: got %b want 1", err_underflow); end
    n_chk++; if (rsp_valid !== 1'b1 || rsp_data !== 128'h77) begin n_fail++; $display("FAIL uf_rsp: got %b/%h want 1/77", rsp_valid, rsp_data); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL uf_cnt_zero: got busy %b want 0", busy); end
    repeat (4) @(negedge clk);
    n_chk++; if ({err_underflow, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL uf_sticky: got %b want 10", {err_underflow, rsp_valid}); end
  endtask

  task automatic test_reset_in_issue();
    int p0;
    @(negedge clk);
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    push(1'b0, 28'h30, '0);
    repeat (2) @(negedge clk);
    n_chk++; if ({busy, app_en} !== 2'b10) begin n_fail++; $display("FAIL rsti_read_out: got %b want 10", {busy, app_en}); end
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    push(1'b1, 28'h40, {8{16'hBEEF}});
    @(negedge clk);
    n_chk++; if ({app_en, app_wdf_wren} !== 2'b11) begin n_fail++; $display("FAIL rsti_in_issue: got %b want 11", {app_en, app_wdf_wren}); end
    p0 = pop_cnt;
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if ({fifo_pop, app_en, app_wdf_wren, app_wdf_end, busy, err_underflow, rsp_valid} !== 7'b0) begin n_fail++; $display("FAIL rsti_outputs: got %b want 0000000", {fifo_pop, app_en, app_wdf_wren, app_wdf_end, busy, err_underflow, rsp_valid}); end
    n_chk++; if ({app_cmd, app_addr, app_wdf_data, rsp_data} !== '0) begin n_fail++; $display("FAIL rsti_buses: got %h/%h/%h/%h want 0", app_cmd, app_addr, app_wdf_data, rsp_data); end
    rst = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (pop_cnt !== p0 || app_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rsti_no_repop: got pops %0d en %b busy %b want 0/0/0", pop_cnt - p0, app_en, busy); end
    app_rd_data_valid = 1'b1;
    @(negedge clk);
    app_rd_data_valid = 1'b0;
    n_chk++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL rsti_cnt_cleared: got err %b want 1", err_underflow); end
  endtask

  initial begin
    rst = 1'b1; calib_done = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    app_rd_data = '0; app_rd_data_valid = 1'b0;
    refresh();
    test_reset();
    test_write();
    test_split_accept();
    test_read_throttle();
    test_calib_hold();
    test_concurrent();
    test_underflow();
    test_reset_in_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no end after 100000 time units want completion");
    $fatal(1);
  end

endmodule
